// File: rtl/rl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rl_pkg
// Brief    : Shared widths, action codes, FSM encoding and reward type for the
//            Q-learning episode sequencer.
// Revision : 1.0
// ============================================================================
package rl_pkg;

   localparam int STATE_W = 6;
   localparam int ACT_W   = 4;

   localparam logic [ACT_W-1:0] ACT_0 = 4'b0000;
   localparam logic [ACT_W-1:0] ACT_1 = 4'b0001;
   localparam logic [ACT_W-1:0] ACT_2 = 4'b0010;
   localparam logic [ACT_W-1:0] ACT_3 = 4'b0011;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_INIT   = 3'd1,
      ST_SELECT = 3'd2,
      ST_MOVE   = 3'd3,
      ST_UPDATE = 3'd4,
      ST_DONE   = 3'd5
   } rl_state_t;

   typedef logic signed [7:0] reward_t;

endpackage : rl_pkg
`default_nettype wire

// File: rtl/rl_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : rl_lfsr16
// Brief    : 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every
//            cycle, reloaded with SEED on reset.
// Revision : 1.0
// ============================================================================
module rl_lfsr16 #(
   parameter int          OUT_W = 16,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic [OUT_W-1:0] o_value
);

   logic [15:0] r_lfsr;
   logic        w_feedback;

   // Right-shifting form: feedback enters at the MSB.
   assign w_feedback = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr <= SEED;
      end else begin
         r_lfsr <= {w_feedback, r_lfsr[15:1]};
      end
   end

   assign o_value = r_lfsr[OUT_W-1:0];

endmodule : rl_lfsr16
`default_nettype wire

// File: rtl/rl_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rl_episode_ctrl
// Brief    : Episode sequencer: query greedy action, step the grid, hand the
//            (s,a,s',r) transition to the Q-update block. Optional epsilon-
//            greedy exploration enabled by macro EPS_GREEDY_EN.
// Revision : 1.0
// ============================================================================
module rl_episode_ctrl
   import rl_pkg::*;
#(
   parameter logic [STATE_W-1:0] START_STATE  = 6'd8,
   parameter logic [STATE_W-1:0] GOAL_STATE   = 6'd63,
   parameter int unsigned        MAX_STEPS    = 64,
   parameter int unsigned        NUM_EPISODES = 16,
`ifdef EPS_GREEDY_EN
   parameter logic [7:0]         EPSILON      = 8'd26,
`endif
   parameter reward_t            REWARD_GOAL  = 8'sd100,
   parameter reward_t            REWARD_WALL  = -8'sd10,
   parameter reward_t            REWARD_STEP  = -8'sd1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic               q_req,
   output logic [STATE_W-1:0] q_state,
   input  logic               q_ack,
   input  logic [ACT_W-1:0]   q_best_action,
   output logic [STATE_W-1:0] ns_state,
   output logic [ACT_W-1:0]   ns_action,
   input  logic [STATE_W-1:0] ns_next,
   output logic               upd_req,
   output logic [STATE_W-1:0] upd_s,
   output logic [ACT_W-1:0]   upd_a,
   output logic [STATE_W-1:0] upd_s_next,
   output reward_t            upd_reward,
   input  logic               upd_ack,
   output logic [7:0]         step_cnt,
   output logic [7:0]         episode_cnt,
   output logic               episode_done,
   output logic               train_done
);

   localparam logic [7:0] c_max_steps    = 8'(MAX_STEPS);
   localparam logic [7:0] c_num_episodes = 8'(NUM_EPISODES);

   rl_state_t          r_state;
   logic [STATE_W-1:0] r_cur_state;
   logic [ACT_W-1:0]   r_action;
   logic [ACT_W-1:0]   w_sel_action;
   logic [7:0]         w_step_inc;
   logic [7:0]         w_ep_inc;
   reward_t            w_reward;

`ifdef EPS_GREEDY_EN
   logic [9:0] w_lfsr;

   rl_lfsr16 #(
      .OUT_W (10),
      .SEED  (16'hACE1)
   ) u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .o_value (w_lfsr)
   );

   assign w_sel_action = (w_lfsr[7:0] < EPSILON) ? {2'b00, w_lfsr[9:8]} : q_best_action;
`else
   assign w_sel_action = q_best_action;
`endif

   assign q_state    = r_cur_state;
   assign ns_state   = r_cur_state;
   assign ns_action  = r_action;
   assign w_step_inc = step_cnt + 8'd1;
   assign w_ep_inc   = (episode_cnt == 8'hFF) ? 8'hFF : episode_cnt + 8'd1;

   // Goal outranks a wall bump when both compare equal.
   always_comb begin
      w_reward = REWARD_STEP;
      if (ns_next == GOAL_STATE) begin
         w_reward = REWARD_GOAL;
      end else if (ns_next == r_cur_state) begin
         w_reward = REWARD_WALL;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_cur_state  <= START_STATE;
         r_action     <= ACT_0;
         q_req        <= 1'b0;
         upd_req      <= 1'b0;
         upd_s        <= '0;
         upd_a        <= '0;
         upd_s_next   <= '0;
         upd_reward   <= '0;
         step_cnt     <= '0;
         episode_cnt  <= '0;
         episode_done <= 1'b0;
         train_done   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  episode_cnt <= '0;
                  train_done  <= 1'b0;
                  r_state     <= ST_INIT;
               end
            end
            ST_INIT: begin
               r_cur_state <= START_STATE;
               step_cnt    <= '0;
               q_req       <= 1'b1;
               r_state     <= ST_SELECT;
            end
            ST_SELECT: begin
               if (q_ack) begin
                  r_action <= w_sel_action;
                  q_req    <= 1'b0;
                  r_state  <= ST_MOVE;
               end
            end
            ST_MOVE: begin
               upd_s      <= r_cur_state;
               upd_a      <= r_action;
               upd_s_next <= ns_next;
               upd_reward <= w_reward;
               upd_req    <= 1'b1;
               r_state    <= ST_UPDATE;
            end
            ST_UPDATE: begin
               if (upd_ack) begin
                  upd_req     <= 1'b0;
                  r_cur_state <= upd_s_next;
                  step_cnt    <= w_step_inc;
                  if ((upd_s_next == GOAL_STATE) || (w_step_inc == c_max_steps)) begin
                     episode_done <= 1'b1;
                     r_state      <= ST_DONE;
                  end else begin
                     q_req   <= 1'b1;
                     r_state <= ST_SELECT;
                  end
               end
            end
            ST_DONE: begin
               episode_done <= 1'b0;
               episode_cnt  <= w_ep_inc;
               if (w_ep_inc == c_num_episodes) begin
                  train_done <= 1'b1;
                  r_state    <= ST_IDLE;
               end else begin
                  step_cnt <= '0;
                  r_state  <= ST_INIT;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule : rl_episode_ctrl
`default_nettype wire

// File: tb/tb_rl_episode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rl_episode_ctrl
// Brief    : Directed self-checking bench for rl_episode_ctrl (MAX_STEPS=4,
//            NUM_EPISODES=2); exploration checks active with EPS_GREEDY_EN.
// Revision : 1.0
// ============================================================================
module tb_rl_episode_ctrl;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              q_req;
   logic [5:0]        q_state;
   logic              q_ack = 1'b0;
   logic [3:0]        q_best_action = 4'd0;
   logic [5:0]        ns_state;
   logic [3:0]        ns_action;
   logic [5:0]        ns_next = 6'd0;
   logic              upd_req;
   logic [5:0]        upd_s;
   logic [3:0]        upd_a;
   logic [5:0]        upd_s_next;
   logic signed [7:0] upd_reward;
   logic              upd_ack = 1'b0;
   logic [7:0]        step_cnt;
   logic [7:0]        episode_cnt;
   logic              episode_done;
   logic              train_done;

   int n_vec = 0;
   int n_err = 0;

   logic [15:0] m_lfsr;

   rl_episode_ctrl #(
`ifdef EPS_GREEDY_EN
      .EPSILON      (8'd255),
`endif
      .MAX_STEPS    (4),
      .NUM_EPISODES (2)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start),
      .q_req         (q_req),
      .q_state       (q_state),
      .q_ack         (q_ack),
      .q_best_action (q_best_action),
      .ns_state      (ns_state),
      .ns_action     (ns_action),
      .ns_next       (ns_next),
      .upd_req       (upd_req),
      .upd_s         (upd_s),
      .upd_a         (upd_a),
      .upd_s_next    (upd_s_next),
      .upd_reward    (upd_reward),
      .upd_ack       (upd_ack),
      .step_cnt      (step_cnt),
      .episode_cnt   (episode_cnt),
      .episode_done  (episode_done),
      .train_done    (train_done)
   );

   always #5 clk = ~clk;

   // Reference exploration generator: 16-bit Fibonacci, taps 16,14,13,11.
   always @(posedge clk) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
   end

   function automatic logic [3:0] exp_action(input logic [3:0] best);
`ifdef EPS_GREEDY_EN
      if (m_lfsr[7:0] < 8'd255) return {2'b00, m_lfsr[9:8]};
`endif
      return best;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_q_req();
      int n = 0;
      while (!q_req && n < 50) begin
         if (train_done) pulse_start();
         else tick();
         n++;
      end
      if (!q_req) begin
         n_vec++; n_err++;
         $display("FAIL q_req_timeout q_req=%b required=1", q_req);
      end
   endtask

   // Returns in the MOVE cycle with the action the DUT should have latched.
   task automatic ack_q(input logic [3:0] best, input logic [5:0] nxt, output logic [3:0] exp);
      exp           = exp_action(best);
      q_ack         = 1'b1;
      q_best_action = best;
      ns_next       = nxt;
      tick();
      q_ack = 1'b0;
   endtask

   task automatic ack_upd();
      upd_ack = 1'b1;
      tick();
      upd_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      n_vec++;
      if ({q_req, upd_req, episode_done, train_done} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags got=%b required=0000", {q_req, upd_req, episode_done, train_done});
      end
      n_vec++;
      if (q_state !== 6'd8 || ns_state !== 6'd8) begin
         n_err++; $display("FAIL reset_state q_state=%0d ns_state=%0d required=8", q_state, ns_state);
      end
      n_vec++;
      if ({ns_action, upd_s, upd_a, upd_s_next, upd_reward, step_cnt, episode_cnt} !== 42'd0) begin
         n_err++; $display("FAIL reset_zero act=%0d s=%0d a=%0d sn=%0d r=%0d sc=%0d ec=%0d required=0",
                           ns_action, upd_s, upd_a, upd_s_next, upd_reward, step_cnt, episode_cnt);
      end
      rst_n = 1'b1;
      repeat (3) begin
         tick();
         n_vec++;
         if (q_req !== 1'b0) begin
            n_err++; $display("FAIL reset_idle q_req=%b required=0", q_req);
         end
      end
   endtask

   task automatic test_greedy();
      logic [3:0] e;
      pulse_start();
      n_vec++;
      if (q_req !== 1'b0) begin n_err++; $display("FAIL init_no_req q_req=%b required=0", q_req); end
      tick();
      n_vec++;
      if (q_req !== 1'b1 || q_state !== 6'd8) begin
         n_err++; $display("FAIL first_req q_req=%b q_state=%0d required=1/8", q_req, q_state);
      end
      ack_q(4'd1, 6'd9, e);
      n_vec++;
      if (q_req !== 1'b0 || ns_action !== e || ns_state !== 6'd8) begin
         n_err++; $display("FAIL move q_req=%b ns_action=%0d ns_state=%0d required=0/%0d/8", q_req, ns_action, ns_state, e);
      end
      tick();
      n_vec++;
      if (upd_req !== 1'b1 || upd_s !== 6'd8 || upd_a !== e || upd_s_next !== 6'd9 || upd_reward !== -8'sd1) begin
         n_err++; $display("FAIL step_xfer req=%b s=%0d a=%0d sn=%0d r=%0d required=1/8/%0d/9/-1",
                           upd_req, upd_s, upd_a, upd_s_next, upd_reward, e);
      end
      tick();
      n_vec++;
      if (upd_req !== 1'b1 || upd_s_next !== 6'd9 || upd_reward !== -8'sd1) begin
         n_err++; $display("FAIL upd_hold req=%b sn=%0d r=%0d required=1/9/-1", upd_req, upd_s_next, upd_reward);
      end
      ack_upd();
      n_vec++;
      if (upd_req !== 1'b0 || q_req !== 1'b1 || q_state !== 6'd9 || step_cnt !== 8'd1) begin
         n_err++; $display("FAIL next_select upd_req=%b q_req=%b q_state=%0d step=%0d required=0/1/9/1",
                           upd_req, q_req, q_state, step_cnt);
      end
   endtask

   task automatic test_wall();
      logic [3:0] e;
      ack_q(4'd2, 6'd9, e);
      tick();
      n_vec++;
      if (upd_reward !== -8'sd10 || upd_s !== 6'd9 || upd_s_next !== 6'd9) begin
         n_err++; $display("FAIL wall r=%0d s=%0d sn=%0d required=-10/9/9", upd_reward, upd_s, upd_s_next);
      end
      ack_upd();
      n_vec++;
      if (q_state !== 6'd9 || step_cnt !== 8'd2) begin
         n_err++; $display("FAIL wall_after q_state=%0d step=%0d required=9/2", q_state, step_cnt);
      end
   endtask

   task automatic test_goal();
      logic [3:0] e;
      ack_q(4'd0, 6'd63, e);
      tick();
      n_vec++;
      if (upd_reward !== 8'sd100 || upd_s_next !== 6'd63) begin
         n_err++; $display("FAIL goal_reward r=%0d sn=%0d required=100/63", upd_reward, upd_s_next);
      end
      ack_upd();
      n_vec++;
      if (episode_done !== 1'b1 || step_cnt !== 8'd3 || q_req !== 1'b0) begin
         n_err++; $display("FAIL goal_done done=%b step=%0d q_req=%b required=1/3/0", episode_done, step_cnt, q_req);
      end
      tick();
      n_vec++;
      if (episode_done !== 1'b0 || episode_cnt !== 8'd1 || train_done !== 1'b0) begin
         n_err++; $display("FAIL goal_after done=%b ep=%0d train=%b required=0/1/0", episode_done, episode_cnt, train_done);
      end
      tick();
      n_vec++;
      if (q_req !== 1'b1 || q_state !== 6'd8 || step_cnt !== 8'd0) begin
         n_err++; $display("FAIL new_episode q_req=%b q_state=%0d step=%0d required=1/8/0", q_req, q_state, step_cnt);
      end
   endtask

   task automatic test_step_limit();
      logic [3:0] e;
      for (int k = 0; k < 4; k++) begin
         wait_q_req();
         ack_q(4'd3, 6'(10 + k), e);
         tick();
         ack_upd();
         n_vec++;
         if (episode_done !== (k == 3) || step_cnt !== 8'(k + 1)) begin
            n_err++; $display("FAIL limit_step%0d done=%b step=%0d required=%0d/%0d", k, episode_done, step_cnt, k == 3, k + 1);
         end
      end
      tick();
      n_vec++;
      if (train_done !== 1'b1 || episode_cnt !== 8'd2 || episode_done !== 1'b0) begin
         n_err++; $display("FAIL run_end train=%b ep=%0d done=%b required=1/2/0", train_done, episode_cnt, episode_done);
      end
      repeat (2) tick();
      n_vec++;
      if (q_req !== 1'b0 || train_done !== 1'b1) begin
         n_err++; $display("FAIL run_idle q_req=%b train=%b required=0/1", q_req, train_done);
      end
   endtask

   task automatic test_back_to_back_episodes();
      logic [3:0] e;
      int pulses = 0;
      int bad_at = 0;
      pulse_start();
      n_vec++;
      if (train_done !== 1'b0 || episode_cnt !== 8'd0) begin
         n_err++; $display("FAIL restart_clear train=%b ep=%0d required=0/0", train_done, episode_cnt);
      end
      for (int k = 1; k <= 8; k++) begin
         wait_q_req();
         ack_q(4'd1, 6'(20 + k), e);
         tick();
         ack_upd();
         if (episode_done) begin
            pulses++;
            if (k != 4 && k != 8) bad_at = k;
         end
      end
      n_vec++;
      if (pulses !== 2 || bad_at !== 0) begin
         n_err++; $display("FAIL limit_pulses pulses=%0d early_at=%0d required=2/0", pulses, bad_at);
      end
      tick();
      n_vec++;
      if (train_done !== 1'b1) begin
         n_err++; $display("FAIL b2b_train train=%b required=1", train_done);
      end
   endtask

   task automatic test_reset_mid_update();
      logic [3:0] e;
      pulse_start();
      wait_q_req();
      ack_q(4'd1, 6'd9, e);
      tick();
      ack_upd();
      ack_q(4'd1, 6'd10, e);
      tick();
      n_vec++;
      if (upd_req !== 1'b1 || step_cnt !== 8'd1) begin
         n_err++; $display("FAIL pre_reset upd_req=%b step=%0d required=1/1", upd_req, step_cnt);
      end
      rst_n = 1'b0;
      tick();
      n_vec++;
      if (upd_req !== 1'b0 || q_req !== 1'b0 || step_cnt !== 8'd0 || q_state !== 6'd8 || episode_cnt !== 8'd0) begin
         n_err++; $display("FAIL mid_reset upd_req=%b q_req=%b step=%0d q_state=%0d ep=%0d required=0/0/0/8/0",
                           upd_req, q_req, step_cnt, q_state, episode_cnt);
      end
      rst_n = 1'b1;
      repeat (3) tick();
      n_vec++;
      if (q_req !== 1'b0 || upd_req !== 1'b0 || train_done !== 1'b0) begin
         n_err++; $display("FAIL post_reset_idle q_req=%b upd_req=%b train=%b required=0/0/0", q_req, upd_req, train_done);
      end
   endtask

   task automatic test_explore();
      logic [3:0] e;
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         wait_q_req();
         ack_q(4'd3, 6'd20, e);
         n_vec++;
         if (ns_action !== e || ns_action[3:2] !== 2'b00) begin
            n_err++; $display("FAIL explore%0d action=%0d required=%0d", i, ns_action, e);
         end
         tick();
         ack_upd();
      end
   endtask

   initial begin
      test_reset();
      test_greedy();
      test_wall();
      test_goal();
      test_step_limit();
      test_back_to_back_episodes();
      test_reset_mid_update();
      test_explore();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_rl_episode_ctrl
`default_nettype wire
